// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding, line type and field-width helpers for assoc_dcache.
package cache_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int WAYS_DEF       = 2;
  localparam int SETS_DEF       = 4;
  localparam int LINE_WORDS_DEF = 4;
  localparam int LINE_BITS_DEF  = LINE_WORDS_DEF * DATA_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_e;

  typedef logic [LINE_BITS_DEF-1:0] line_t;

  // Byte-offset bits inside a line of 4-byte words
  function automatic int offset_bits(input int line_words);
    return $clog2(line_words * 4);
  endfunction

  // Set-index bits
  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

endpackage

// File: rtl/dcache_way.sv
// dcache_way: tag/valid/dirty/data storage for one cache way with tag compare.
// Valid and dirty are cleared by reset; tags and line data are not.
module dcache_way #(
  parameter int SETS      = 4,
  parameter int IDX_W     = 2,
  parameter int TAG_W     = 26,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     index,
  input  logic [TAG_W-1:0]     tag,
  input  logic                 wr_en,
  input  logic [LINE_BITS-1:0] wr_line,
  input  logic                 wr_dirty,
  output logic                 hit,
  output logic                 valid,
  output logic                 dirty,
  output logic [TAG_W-1:0]     tag_out,
  output logic [LINE_BITS-1:0] line_out
);

  logic [SETS-1:0]      valid_q, valid_d;
  logic [SETS-1:0]      dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [LINE_BITS-1:0] line_q [SETS];

  // Next valid/dirty state: a write always leaves the selected set valid
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en) begin
      valid_d[index] = 1'b1;
      dirty_d[index] = wr_dirty;
    end
  end

  // Control bits are reset, storage arrays are not
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and line storage, written on store hit or refill
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[index]  <= tag;
      line_q[index] <= wr_line;
    end
  end

  assign valid    = valid_q[index];
  assign dirty    = dirty_q[index];
  assign tag_out  = tag_q[index];
  assign line_out = line_q[index];
  assign hit      = valid_q[index] && (tag_q[index] == tag);

endmodule

// File: rtl/assoc_dcache.sv
// assoc_dcache: set-associative, write-back, write-allocate data cache.
// Hits complete combinationally; a miss stalls and runs writeback/refill with memory.
// Optional feature macro: CACHE_STATS_EN adds hit_count/miss_count outputs.
module assoc_dcache
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int WAYS       = WAYS_DEF,
  parameter int SETS       = SETS_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            data_address,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic                             MemRead,
  input  logic                             MemWrite,
  input  logic                             AddrMode,
  output logic [DATA_WIDTH-1:0]            read_data,
  output logic                             stall,
  output logic                             mem_req,
  output logic                             WriteEnable,
  output logic [ADDR_WIDTH-1:0]            memory_address,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] mem_writedata,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] mem_readdata,
  input  logic                             mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                      hit_count,
  output logic [31:0]                      miss_count
`endif
);

  localparam int LINE_BITS = LINE_WORDS * DATA_WIDTH;
  localparam int OFF_W     = offset_bits(LINE_WORDS);
  localparam int IDX_W     = index_bits(SETS);
  localparam int TAG_W     = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int WSEL_W    = OFF_W - 2;

  logic [TAG_W-1:0]     tag;
  logic [IDX_W-1:0]     idx;
  logic [WSEL_W-1:0]    wsel;
  logic [1:0]           bsel;

  logic [WAYS-1:0]      way_hit, way_valid, way_dirty, way_wr_en;
  logic [TAG_W-1:0]     way_tag  [WAYS];
  logic [LINE_BITS-1:0] way_line [WAYS];

  logic                 access, hit, hit_any, hit_sel, victim, miss_start, refill_done;
  logic [LINE_BITS-1:0] hit_line, store_line, wr_line;
  logic [DATA_WIDTH-1:0] hit_word, new_word;
  logic [7:0]           hit_byte;
  logic                 wr_dirty;
  logic [SETS-1:0]      lru_q, lru_d;

  state_e               state_q;
  logic                 mem_req_q, we_q;
  logic [ADDR_WIDTH-1:0] maddr_q;
  logic [LINE_BITS-1:0] mem_writedata_q;

  assign tag  = data_address[ADDR_WIDTH-1 -: TAG_W];
  assign idx  = data_address[OFF_W +: IDX_W];
  assign wsel = data_address[2 +: WSEL_W];
  assign bsel = data_address[1:0];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way #(
      .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_BITS(LINE_BITS)
    ) u_way (
      .clk(clk), .rst(rst), .index(idx), .tag(tag),
      .wr_en(way_wr_en[w]), .wr_line(wr_line), .wr_dirty(wr_dirty),
      .hit(way_hit[w]), .valid(way_valid[w]), .dirty(way_dirty[w]),
      .tag_out(way_tag[w]), .line_out(way_line[w])
    );
  end

  // Hit detection, victim choice (invalid way first, else LRU), load data and store merge
  always_comb begin
    hit_any = 1'b0;
    hit_sel = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_any = 1'b1;
        hit_sel = 1'(w);
      end
    end
    if (!way_valid[0])                       victim = 1'b0;
    else if (WAYS > 1 && !way_valid[WAYS-1]) victim = 1'b1;
    else if (WAYS > 1)                       victim = lru_q[idx];
    else                                     victim = 1'b0;
    hit_line = way_line[hit_sel];
    hit_word = hit_line[wsel*DATA_WIDTH +: DATA_WIDTH];
    hit_byte = hit_word[bsel*8 +: 8];
    new_word = hit_word;
    if (AddrMode) new_word[bsel*8 +: 8] = write_data[7:0];
    else          new_word = write_data;
    store_line = hit_line;
    store_line[wsel*DATA_WIDTH +: DATA_WIDTH] = new_word;
  end

  assign access      = MemRead | MemWrite;
  assign hit         = access && (state_q == IDLE) && hit_any;
  assign miss_start  = access && (state_q == IDLE) && !hit_any;
  assign refill_done = (state_q == REFILL) && mem_ready && !rst;
  assign stall       = (state_q != IDLE) || miss_start;
  assign read_data   = hit ? (AddrMode ? DATA_WIDTH'(hit_byte) : hit_word) : '0;
  assign wr_line     = refill_done ? mem_readdata : store_line;
  assign wr_dirty    = !refill_done;

  // Way write enables: store hit into the hitting way, refill into the victim way
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      way_wr_en[w] = !rst && ((hit && MemWrite && (hit_sel == 1'(w))) ||
                              (refill_done && (victim == 1'(w))));
    end
  end

  // LRU update: after a hit the other way becomes least recently used
  always_comb begin
    lru_d = lru_q;
    if (hit && WAYS > 1) lru_d[idx] = ~hit_sel;
  end

  // LRU state register
  always_ff @(posedge clk) begin
    if (rst) lru_q <= '0;
    else     lru_q <= lru_d;
  end

  // Miss FSM with registered memory-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      we_q      <= 1'b0;
      maddr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_start) begin
            mem_req_q <= 1'b1;
            if (way_valid[victim] && way_dirty[victim]) begin
              state_q <= WRITEBACK;
              we_q    <= 1'b1;
              maddr_q <= {way_tag[victim], idx, {OFF_W{1'b0}}};
            end else begin
              state_q <= REFILL;
              we_q    <= 1'b0;
              maddr_q <= {tag, idx, {OFF_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            state_q <= REFILL;
            we_q    <= 1'b0;
            maddr_q <= {tag, idx, {OFF_W{1'b0}}};
          end
        end
        REFILL: begin
          if (mem_ready) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Victim line captured when the miss is accepted
  always_ff @(posedge clk) begin
    if (miss_start) mem_writedata_q <= way_line[victim];
  end

  assign mem_req        = mem_req_q;
  assign WriteEnable    = we_q;
  assign memory_address = maddr_q;
  assign mem_writedata  = mem_writedata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;
  logic        first_after_refill_q;

  // Access statistics; the replayed hit right after a refill is not a real hit
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q          <= '0;
      miss_count_q         <= '0;
      first_after_refill_q <= 1'b0;
    end else begin
      first_after_refill_q <= refill_done;
      if (miss_start)                   miss_count_q <= miss_count_q + 32'd1;
      if (hit && !first_after_refill_q) hit_count_q  <= hit_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_assoc_dcache.sv
// tb_assoc_dcache: scoreboard bench for assoc_dcache with an LRU-list cache model,
// an architectural memory image and a line-wide backing memory responder.
module tb_assoc_dcache;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_address = '0;
  logic [31:0] write_data = '0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, AddrMode = 1'b0;
  logic [31:0] read_data;
  logic        stall, mem_req, WriteEnable;
  logic [31:0] memory_address;
  line_t       mem_writedata;
  line_t       mem_readdata = '0;
  logic        mem_ready = 1'b0;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  assoc_dcache dut (
    .clk(clk), .rst(rst), .data_address(data_address), .write_data(write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .AddrMode(AddrMode),
    .read_data(read_data), .stall(stall), .mem_req(mem_req), .WriteEnable(WriteEnable),
    .memory_address(memory_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_ready(mem_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          we;
    logic [31:0] addr;
  } mtx_t;

  mtx_t        exp_mem[$];
  logic [31:0] exp_rd[$];
  logic [31:0] ref_mem [int unsigned];   // architectural memory image
  logic [31:0] bk_mem  [int unsigned];   // backing memory contents
  int unsigned lst [4][2];               // per set: [0] = MRU line, [1] = LRU line
  int          n   [4];
  bit          dirty_m [int unsigned];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] bk_get(input logic [31:0] a);
    return bk_mem.exists(a) ? bk_mem[a] : init_val(a);
  endfunction

  // Cache occupancy model: LRU list per set; returns expected stall cycles
  task automatic model_access(input logic [31:0] a, input bit wr, output int st);
    int unsigned line, vic;
    int          s;
    line = a & 32'hFFFF_FFF0;
    s    = int'((a >> 4) & 32'h3);
    if (n[s] > 0 && lst[s][0] == line) begin
      st = 0;
    end else if (n[s] > 1 && lst[s][1] == line) begin
      lst[s][1] = lst[s][0];
      lst[s][0] = line;
      st = 0;
    end else begin
      st = 4;
      if (n[s] == 2) begin
        vic = lst[s][1];
        if (dirty_m.exists(vic)) begin
          exp_mem.push_back('{we: 1'b1, addr: vic});
          dirty_m.delete(vic);
          st = 7;
        end
      end else begin
        n[s]++;
      end
      exp_mem.push_back('{we: 1'b0, addr: line});
      lst[s][1] = lst[s][0];
      lst[s][0] = line;
    end
    if (wr) dirty_m[line] = 1'b1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) n[s] = 0;
    dirty_m.delete();
    exp_mem.delete();
    ref_mem.delete();
    foreach (bk_mem[k]) ref_mem[k] = bk_mem[k];
  endtask

  // One CPU access; called at posedge+1, returns at posedge+1 after completion
  task automatic do_access(input logic [31:0] a, input logic [31:0] wd,
                           input bit rd, input bit wr, input bit bm);
    int          exp_st, st;
    logic [31:0] w, wa;
    data_address = a; write_data = wd; MemRead = rd; MemWrite = wr; AddrMode = bm;
    if (rd || wr) begin
      model_access(a, wr, exp_st);
      wa = a & 32'hFFFF_FFFC;
      w  = ref_get(wa);
      if (wr) begin
        if (bm) w[8*a[1:0] +: 8] = wd[7:0];
        else    w = wd;
        ref_mem[wa] = w;
      end else begin
        exp_rd.push_back(bm ? ((w >> (8*a[1:0])) & 32'hFF) : w);
      end
      st = 0;
      @(negedge clk);
      while (stall && st < 20) begin
        st++;
        @(negedge clk);
      end
      check("stall_cycles", st, exp_st);
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every completed load is compared against the scoreboard queue
  logic [31:0] mon_e;
  always @(negedge clk) begin
    if (!rst && MemRead && !MemWrite && !stall) begin
      if (exp_rd.size() == 0) check("rd_queue_empty", 1, 0);
      else begin
        mon_e = exp_rd.pop_front();
        check("read_data", read_data, mon_e);
      end
    end
  end

  // Backing memory: ready in the third cycle of each request
  int   mcnt = 0;
  mtx_t mt;
  logic [31:0] wbw;
  initial begin
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_req && !rst) begin
        if (mcnt == 2) begin
          mcnt = 0;
          mem_ready = 1'b1;
          if (exp_mem.size() == 0) check("mem_unexpected", 1, 0);
          else begin
            mt = exp_mem.pop_front();
            check("mem_we", WriteEnable, mt.we);
            check("mem_addr", memory_address, mt.addr);
          end
          for (int i = 0; i < 4; i++) begin
            if (WriteEnable) begin
              wbw = mem_writedata[32*i +: 32];
              check("wb_data", wbw, ref_get(memory_address + 32'(4*i)));
              bk_mem[memory_address + 32'(4*i)] = wbw;
            end else begin
              mem_readdata[32*i +: 32] = bk_get(memory_address + 32'(4*i));
            end
          end
        end else begin
          mcnt++;
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int op;
  logic [31:0] ra;
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_we", WriteEnable, 0);
    check("rst_read_data", read_data, 0);
    rst = 1'b0;

    bk_mem[32'h10] = 32'h11; bk_mem[32'h14] = 32'h22;
    bk_mem[32'h18] = 32'h33; bk_mem[32'h1C] = 32'h44;
    bk_mem[32'h20] = 32'h12345678;
    model_reset();

    // Cold load and same-line hit
    do_access(32'h10, 32'h0, 1, 0, 0);
    do_access(32'h14, 32'h0, 1, 0, 0);
`ifdef CACHE_STATS_EN
    check("hit_count", hit_count, 1);
    check("miss_count", miss_count, 1);
`endif
    // Dirty eviction in set 1
    do_access(32'h10, 32'hDEADBEEF, 0, 1, 0);
    do_access(32'h50, 32'h0, 1, 0, 0);
    do_access(32'h90, 32'h0, 1, 0, 0);
    // LRU replacement
    do_access(32'h10, 32'h0, 1, 0, 0);
    do_access(32'h50, 32'h0, 1, 0, 0);
    do_access(32'h10, 32'h0, 1, 0, 0);
    do_access(32'h90, 32'h0, 1, 0, 0);
    // Byte mode
    do_access(32'h22, 32'h0, 1, 0, 1);
    do_access(32'h21, 32'hC3C3C3AB, 0, 1, 1);
    do_access(32'h20, 32'h0, 1, 0, 0);

    // Reset in the middle of a refill
    data_address = 32'h30; MemRead = 1'b1; MemWrite = 1'b0; AddrMode = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; MemRead = 1'b0;
    @(negedge clk);
    check("rst_abort_mem_req", mem_req, 0);
    check("rst_abort_stall", stall, 0);
    @(posedge clk); #1;
    model_reset();
    do_access(32'h30, 32'h0, 1, 0, 0);

    // Randomized traffic over a small conflicting footprint
    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 4));
      ra = $urandom_range(0, 255);
      case (op)
        0:       do_access(ra, $urandom, 0, 0, 1'($urandom_range(0, 1)));
        1, 2:    do_access(ra, $urandom, 1, 0, 1'($urandom_range(0, 1)));
        3:       do_access(ra, $urandom, 0, 1, 1'($urandom_range(0, 1)));
        default: do_access(ra, $urandom, 1, 1, 1'($urandom_range(0, 1)));
      endcase
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    repeat (2) @(posedge clk);
    check("mem_queue_drained", exp_mem.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
